// File: rtl/max_accelerator.sv
// Streaming signed-maximum reduction over dataValid-framed batches.
// The batch maximum is published on dataOut on the first idle edge after a batch.
module max_accelerator #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  dataValid,
    output logic [DATA_WIDTH-1:0] dataOut
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [DATA_WIDTH-1:0] max_r;
    logic [DATA_WIDTH-1:0] max_s;
    logic [DATA_WIDTH-1:0] out_r;
    logic [DATA_WIDTH-1:0] out_s;
    logic                  greater_s;

    // Full-width two's-complement compare; a tie keeps the current max.
    assign greater_s = ($signed(dataIn) > $signed(max_r));

    // Next-state, running-max and result selection.
    always_comb begin
        state_s = state_r;
        max_s   = max_r;
        out_s   = out_r;
        case (state_r)
            IDLE: begin
                if (dataValid) begin
                    // First sample seeds the max so no stale value is ever compared.
                    max_s   = dataIn;
                    state_s = ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (dataValid) begin
                    if (greater_s) begin
                        max_s = dataIn;
                    end else begin
                        max_s = max_r;
                    end
                    state_s = ACCUM;
                end else begin
                    out_s   = max_r;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                max_s   = {DATA_WIDTH{1'b0}};
                out_s   = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // State, running max and published result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            max_r   <= {DATA_WIDTH{1'b0}};
            out_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            max_r   <= max_s;
            out_r   <= out_s;
        end
    end

    assign dataOut = out_r;

endmodule

// File: tb/tb_max_accelerator.sv
// Self-checking bench for max_accelerator: directed test-plan batches followed by
// randomized batches, all checked every cycle against a queue-based batch-max model.
module tb_max_accelerator;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic [DW-1:0] dataIn;
    logic          dataValid;
    logic [DW-1:0] dataOut;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: samples of the open batch and the last published maximum.
    logic [DW-1:0] batch_q[$];
    logic [DW-1:0] exp_out;

    max_accelerator #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataIn    (dataIn),
        .dataValid (dataValid),
        .dataOut   (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] batch_max();
        logic signed [DW-1:0] m;
        m = batch_q[0];
        foreach (batch_q[i]) begin
            if ($signed(batch_q[i]) > m) m = batch_q[i];
        end
        return m;
    endfunction

    // One clock: drive inputs, advance the model at the edge, check on the falling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
        reset     = r;
        dataValid = v;
        dataIn    = d;
        @(posedge clk);
        if (r) begin
            batch_q.delete();
            exp_out = '0;
        end else if (v) begin
            batch_q.push_back(d);
        end else if (batch_q.size() > 0) begin
            exp_out = batch_max();
            batch_q.delete();
        end
        @(negedge clk);
        check_eq("cyc", dataOut, exp_out);
    endtask

    task automatic batch4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic [DW-1:0] prev;
        prev = dataOut;
        cycle(1'b1, a, 1'b0);
        cycle(1'b1, b, 1'b0);
        cycle(1'b1, c, 1'b0);
        cycle(1'b1, d, 1'b0);
        check_eq("no_intermediate", dataOut, prev);
        cycle(1'b0, $urandom, 1'b0);
    endtask

    function automatic logic [DW-1:0] rand_sample();
        logic [DW-1:0] s;
        case ($urandom_range(0, 4))
            0:       s = 32'h8000_0000;
            1:       s = 32'h7FFF_FFFF;
            2:       s = 32'hFF00_0000 + $urandom_range(0, 32'h0200_0000);
            default: s = $urandom;
        endcase
        return s;
    endfunction

    initial begin
        exp_out   = '0;
        reset     = 1'b1;
        dataValid = 1'b0;
        dataIn    = '0;
        cycle(1'b0, 32'h0000_0000, 1'b1);
        cycle(1'b1, 32'h1234_5678, 1'b1);
        check_eq("reset", dataOut, 32'h0000_0000);
        cycle(1'b0, 32'h5555_5555, 1'b0);
        check_eq("idle_after_reset", dataOut, 32'h0000_0000);

        batch4(32'h0080_0000, 32'h0380_0000, 32'h0280_0000, 32'h0180_0000);
        check_eq("mid_max", dataOut, 32'h0380_0000);
        batch4(32'h0400_0000, 32'h0300_0000, 32'h0200_0000, 32'h0100_0000);
        check_eq("first_max", dataOut, 32'h0400_0000);
        batch4(32'hFE00_0000, 32'hFD00_0000, 32'h0000_0000, 32'hFF00_0000);
        check_eq("signed_zero", dataOut, 32'h0000_0000);
        batch4(32'hFE00_0000, 32'hFD00_0000, 32'hFC00_0000, 32'hFF00_0000);
        check_eq("all_negative", dataOut, 32'hFF00_0000);

        cycle(1'b1, 32'h8000_0000, 1'b0);
        check_eq("hold_prev", dataOut, 32'hFF00_0000);
        cycle(1'b0, 32'h7FFF_FFFF, 1'b0);
        check_eq("single_min", dataOut, 32'h8000_0000);
        cycle(1'b0, 32'h7FFF_FFFF, 1'b0);
        check_eq("ignore_idle_data", dataOut, 32'h8000_0000);

        cycle(1'b1, 32'h0500_0000, 1'b0);
        cycle(1'b1, 32'h0600_0000, 1'b0);
        cycle(1'b1, 32'h0700_0000, 1'b1);
        check_eq("reset_mid", dataOut, 32'h0000_0000);
        cycle(1'b0, 32'h0900_0000, 1'b0);
        check_eq("partial_discarded", dataOut, 32'h0000_0000);
        cycle(1'b1, 32'h0100_0000, 1'b0);
        cycle(1'b0, 32'h0000_0000, 1'b0);
        check_eq("after_reset_batch", dataOut, 32'h0100_0000);

        for (int n = 0; n < 300; n++) begin
            int len;
            int gap;
            int rst_at;
            len    = $urandom_range(1, 8);
            gap    = $urandom_range(1, 3);
            rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int k = 0; k < len; k++) begin
                cycle(1'b1, rand_sample(), (k == rst_at) ? 1'b1 : 1'b0);
            end
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, $urandom, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
